// File: rtl/comp_to_sm.sv
// Serial two's-complement to sign-magnitude converter.
// Builds the magnitude LSB-first with the copy-to-first-1-then-invert rule.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready for a word; in_ready=1
// S_SHIFT | processing magnitude bit cnt (0..WIDTH-2), one per clock
// S_DONE  | result held on out_data/out_ovf until out_ready
module comp_to_sm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int MW = WIDTH - 1;
  localparam int CW = (MW > 1) ? $clog2(MW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MW - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("comp_to_sm: WIDTH must be in 2..32");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   word_q, word_d;
  logic [MW-1:0]   mag_q, mag_d;
  logic [MW-1:0]   mag_upd;
  logic            sign_q, sign_d;
  logic            seen_q, seen_d;
  logic            seen_upd;
  logic            bit_in, bit_out;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic            ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      seen_q  <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ovf_d   = ovf_q;

    // The first 1 is copied; only bits above it are inverted for negatives.
    bit_in   = word_q[cnt_q];
    bit_out  = bit_in ^ (sign_q & seen_q);
    seen_upd = seen_q | bit_in;
    mag_upd  = mag_q;
    mag_upd[cnt_q] = bit_out;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          word_d  = in_data[MW-1:0];
          sign_d  = in_data[WIDTH-1];
          seen_d  = 1'b0;
          mag_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        mag_d  = mag_upd;
        seen_d = seen_upd;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          // A negative word with no 1 in its magnitude is the most negative
          // value; saturate to -(2^(WIDTH-1)-1) rather than emit negative zero.
          if (sign_q && !seen_upd) begin
            data_d = '1;
            ovf_d  = 1'b1;
          end else begin
            data_d = {sign_q, mag_upd};
            ovf_d  = 1'b0;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = data_q;
  assign out_ovf   = ovf_q;

endmodule

// File: doc/comp_to_sm.md
Name: comp_to_sm

Overview:
Serial converter from two's-complement to sign-magnitude, the inverse of the team's sign-magnitude-to-complement logic. It accepts one WIDTH-bit two's-complement word over a valid/ready handshake. It produces the magnitude LSB-first, one bit per clock, using the copy-to-first-1-then-invert rule. It then presents the sign-magnitude word on an output valid/ready port. It sits on the datapath wherever complement results must be handed back to sign-magnitude consumers.

Parameters:
WIDTH, 8, total word width including sign bit; legal range 2..32.

Ports:
clk  input  1  rising-edge clock; sole clock domain
rst  input  1  synchronous, active-high reset
in_valid  input  1  producer has a word on in_data
in_ready  output  1  block can accept a word; high only in IDLE
in_data  input  WIDTH  two's-complement operand; bit WIDTH-1 is the sign
out_valid  output  1  out_data/out_ovf hold a result
out_ready  input  1  consumer accepts the result
out_data  output  WIDTH  sign-magnitude result; bit WIDTH-1 is the sign
out_ovf  output  1  input was -2^(WIDTH-1), which has no sign-magnitude encoding; result saturated

Behaviour:
- Clocking/reset: one clock, clk. Reset rst is synchronous and active-high. All state is updated on the rising edge of clk only.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_ovf=0, bit counter=0, internal shift/flag registers=0.
- Reset during SHIFT or DONE: the in-flight word is dropped silently and no output is produced for it.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at an edge: latch in_data into the shift register, latch sign = in_data[WIDTH-1], clear seen_one, set cnt=0, go to SHIFT.
  - When in_valid=0: stay in IDLE.
- SHIFT:
  - in_ready=0; in_valid is ignored.
  - Each edge processes magnitude bit cnt (0..WIDTH-2), LSB first.
  - If sign=0: output bit = input bit.
  - If sign=1: output bit = input bit XOR seen_one. seen_one is set after any processed input bit equal to 1; the first 1 is itself copied.
  - cnt increments each edge. On the edge that processes bit WIDTH-2: go to DONE, set out_valid=1, and load out_data and out_ovf.
- Result formation on DONE entry:
  - out_data[WIDTH-1] = sign; out_data[WIDTH-2:0] = assembled magnitude.
  - Overflow case: sign=1 with seen_one=0 over all magnitude bits (input 100...0). Then out_data = {1, all ones}, i.e. -(2^(WIDTH-1)-1), and out_ovf=1.
  - Every other case: out_ovf=0.
  - Input 0 yields 0. The block never emits negative zero (1000...0).
- Latency: result valid WIDTH-1 edges after the accepting edge (7 for WIDTH=8).
- DONE:
  - out_valid=1; out_data and out_ovf stable while out_ready=0 (arbitrarily long backpressure).
  - On an edge with out_ready=1: out_valid drops to 0 and the FSM goes to IDLE.
  - No same-cycle accept in DONE (in_ready=0).
  - Maximum throughput: one word per WIDTH+1 edges.
- After handoff: out_data/out_ovf retain the last result until the next DONE entry; consumers qualify them with out_valid only.
- Input timing: in_data is sampled only on the accepting edge; later changes have no effect on the in-flight word.

Test Plan:
- WIDTH=8, in_data=0x05 accepted at edge k -> out_valid=1 after edge k+7, out_data=0x05, out_ovf=0; out_ready=1 -> out_valid=0 next edge, in_ready=1.
- Negative values: 0xFB -> 0x85; 0xFF -> 0x81; 0x81 -> 0xFF; 0x00 -> 0x00; all with out_ovf=0.
- Overflow: 0x80 -> out_data=0xFF, out_ovf=1.
- Backpressure: convert 0xF0 (-> 0x90), hold out_ready=0 for 5 cycles while pulsing in_valid with 0x33 -> out_data stays 0x90, in_ready=0, 0x33 not consumed; release -> exactly one handoff.
- Reset mid-operation: assert rst for one edge at cnt=3 while converting 0xC4 -> out_valid=0, out_data=0, in_ready=1 after that edge; then 0x7F -> 0x7F.
- Exhaustive sweep 0x00..0xFF back-to-back with random out_ready -> each result matches the reference model (negate magnitude for negatives, saturate 0x80); count of handoffs = 256.
